// File: rtl/rv32_multicycle_ctrl_if.sv
// Instruction/data memory handshake bundle between the multi-cycle controller and the memories.
interface rv32_multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    input  imem_ready,
    output dmem_req,
    output dmem_we,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    output imem_ready,
    input  dmem_req,
    input  dmem_we,
    output dmem_ready
  );
endinterface

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback over a shared datapath.
// Optional trap on unsupported opcodes when ILLEGAL_INSTR_TRAP_EN is defined.
module rv32_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TO_W        = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  rv32_multicycle_ctrl_if.master        mem,
  input  logic [31:0]                   instr,
  input  logic                          br_taken,
  output logic                          ir_we,
  output logic                          pc_we,
  output logic [1:0]                    pc_sel,
  output logic [1:0]                    alu_a_sel,
  output logic                          alu_b_sel,
  output logic                          rf_we,
  output logic [1:0]                    wb_sel,
  output logic                          retire,
  output logic                          bus_err,
`ifdef ILLEGAL_INSTR_TRAP_EN
  output logic                          illegal,
`endif
  output logic [2:0]                    state_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  localparam bit          ToEn   = (MEM_TIMEOUT != 0);
  localparam int unsigned ToLast = ToEn ? MEM_TIMEOUT - 1 : 0;

  state_e          state_q;
  logic [TO_W-1:0] wait_q;
  logic            imem_req_q;
  logic            dmem_req_q;
  logic            dmem_we_q;
  logic            bus_err_q;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  logic       legal;
  logic       to_hit;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign rd           = instr[11:7];
  assign unused_instr = ^instr[31:12];

  always_comb begin
    is_lui    = (opcode == OpLui);
    is_auipc  = (opcode == OpAuipc);
    is_jal    = (opcode == OpJal);
    is_jalr   = (opcode == OpJalr);
    is_branch = (opcode == OpBranch);
    is_load   = (opcode == OpLoad);
    is_store  = (opcode == OpStore);
    is_opimm  = (opcode == OpOpImm);
    is_op     = (opcode == OpOp);
    legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                is_opimm | is_op;
  end

  // Wait counter reaches its last allowed cycle; ready in the same cycle still wins.
  assign to_hit = ToEn && (wait_q == TO_W'(ToLast));

`ifdef ILLEGAL_INSTR_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      bus_err_q  <= 1'b0;
`ifdef ILLEGAL_INSTR_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end
        StFetch: begin
          if (mem.imem_ready) begin
            state_q    <= StDecode;
            imem_req_q <= 1'b0;
            wait_q     <= '0;
          end else if (to_hit) begin
            state_q    <= StHalt;
            imem_req_q <= 1'b0;
            bus_err_q  <= 1'b1;
            wait_q     <= '0;
          end else if (ToEn) begin
            wait_q <= wait_q + TO_W'(1);
          end
        end
        StDecode: begin
`ifdef ILLEGAL_INSTR_TRAP_EN
          if (!legal) begin
            state_q   <= StHalt;
            illegal_q <= 1'b1;
          end else begin
            state_q <= StExec;
          end
`else
          state_q <= StExec;
`endif
        end
        StExec: begin
          if (is_branch) begin
            state_q    <= StFetch;
            imem_req_q <= 1'b1;
          end else if (is_load || is_store) begin
            state_q    <= StMem;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_store;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (mem.dmem_ready) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            wait_q     <= '0;
            if (is_store) begin
              state_q    <= StFetch;
              imem_req_q <= 1'b1;
            end else begin
              state_q <= StWb;
            end
          end else if (to_hit) begin
            state_q    <= StHalt;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            bus_err_q  <= 1'b1;
            wait_q     <= '0;
          end else if (ToEn) begin
            wait_q <= wait_q + TO_W'(1);
          end
        end
        StWb: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end
        StHalt: ;
        default: state_q <= StHalt;
      endcase
    end
  end

  // Handshake-qualified enables follow ready in the same cycle; selects follow the opcode.
  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_a_sel = 2'd0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    retire    = 1'b0;

    if (state_q inside {StDecode, StExec, StMem, StWb}) begin
      if (is_lui) begin
        alu_a_sel = 2'd2;
      end else if (is_auipc || is_jal) begin
        alu_a_sel = 2'd1;
      end
      alu_b_sel = is_opimm | is_load | is_store | is_jalr | is_lui | is_auipc | is_jal;
    end

    unique case (state_q)
      StFetch: ir_we = mem.imem_ready;
      StExec: begin
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? 2'd1 : 2'd0;
          retire = 1'b1;
        end
      end
      StMem: begin
        if (mem.dmem_ready && is_store) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      StWb: begin
        rf_we  = legal && (rd != 5'd0);
        wb_sel = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        pc_we  = 1'b1;
        pc_sel = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem.imem_req = imem_req_q;
  assign mem.dmem_req = dmem_req_q;
  assign mem.dmem_we  = dmem_we_q;
  assign bus_err      = bus_err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Bench for rv32_multicycle_ctrl: table and random instructions checked cycle by cycle against a
// trace built from the instruction's phase sequence, plus timeout and async-reset sequences.
`timescale 1ns/1ps
module tb_rv32_multicycle_ctrl;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [1:0] a_sel;
    logic       b_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       retire;
    logic       bus_err;
  } out_t;

  typedef struct {
    logic [31:0] ins;
    logic        br;
    int          di;
    int          dd;
    int          exp_lat;
    int          exp_rfw;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [31:0] instr;
  logic        br_taken, imem_ready, dmem_ready;
  logic        use2;
  int          n_vec, n_bad;

  always #5 clk = ~clk;

  rv32_multicycle_ctrl_if m1 ();
  rv32_multicycle_ctrl_if m2 ();
  assign m1.imem_ready = imem_ready;
  assign m1.dmem_ready = dmem_ready;
  assign m2.imem_ready = imem_ready;
  assign m2.dmem_ready = dmem_ready;

  logic       ir_we1, pc_we1, b_sel1, rf_we1, retire1, bus_err1;
  logic [1:0] pc_sel1, a_sel1, wb_sel1;
  logic [2:0] st1;
  logic       ir_we2, pc_we2, b_sel2, rf_we2, retire2, bus_err2;
  logic [1:0] pc_sel2, a_sel2, wb_sel2;
  logic [2:0] st2;
  out_t       act1, act2;

  rv32_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem(m1), .instr(instr), .br_taken(br_taken),
    .ir_we(ir_we1), .pc_we(pc_we1), .pc_sel(pc_sel1), .alu_a_sel(a_sel1),
    .alu_b_sel(b_sel1), .rf_we(rf_we1), .wb_sel(wb_sel1), .retire(retire1),
    .bus_err(bus_err1), .state_o(st1)
  );

  rv32_multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut_to (
    .clk(clk), .rst_n(rst2_n), .mem(m2), .instr(instr), .br_taken(br_taken),
    .ir_we(ir_we2), .pc_we(pc_we2), .pc_sel(pc_sel2), .alu_a_sel(a_sel2),
    .alu_b_sel(b_sel2), .rf_we(rf_we2), .wb_sel(wb_sel2), .retire(retire2),
    .bus_err(bus_err2), .state_o(st2)
  );

  assign act1 = {st1, m1.imem_req, m1.dmem_req, m1.dmem_we, ir_we1, pc_we1, pc_sel1, a_sel1,
                 b_sel1, rf_we1, wb_sel1, retire1, bus_err1};
  assign act2 = {st2, m2.imem_req, m2.dmem_req, m2.dmem_we, ir_we2, pc_we2, pc_sel2, a_sel2,
                 b_sel2, rf_we2, wb_sel2, retire2, bus_err2};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic out_t sel_of(input logic [6:0] op);
    out_t s = '0;
    case (op)
      OpOpImm, OpLoad, OpStore, OpJalr: s.b_sel = 1'b1;
      OpLui:          begin s.a_sel = 2'd2; s.b_sel = 1'b1; end
      OpAuipc, OpJal: begin s.a_sel = 2'd1; s.b_sel = 1'b1; end
      default: ;
    endcase
    return s;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad, OpStore, OpOpImm, OpOp};
  endfunction

  function automatic int lat_rule(input logic [6:0] op, input int di, input int dd);
    if (op == OpBranch) return 3 + di;
    if (op == OpStore)  return 4 + di + dd;
    if (op == OpLoad)   return 5 + di + dd;
    return 4 + di;
  endfunction

  function automatic int rfw_rule(input logic [31:0] ins);
    if (!is_legal(ins[6:0]) || ins[6:0] inside {OpBranch, OpStore}) return 0;
    return (ins[11:7] != 5'd0) ? 1 : 0;
  endfunction

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return OpLui;    1: return OpAuipc; 2: return OpJal;    3: return OpJalr;
      4: return OpBranch; 5: return OpLoad;  6: return OpStore;  7: return OpOpImm;
      8: return OpOp;     9: return 7'b0001111; 10: return 7'b1110011;
      default: return 7'b1111111;
    endcase
  endfunction

  // One cycle: drive inputs just after the rising edge, compare on the falling edge.
  task automatic step(input logic [31:0] ins, input logic br, input logic ir, input logic dr,
                      input out_t e, inout int n, inout int ret_at, inout int nrfw);
    out_t a;
    instr = ins; br_taken = br; imem_ready = ir; dmem_ready = dr;
    @(negedge clk);
    a = use2 ? act2 : act1;
    n++;
    chk($sformatf("cycle %0d of %h", n, ins), 32'(a), 32'(e));
    if (a.retire && ret_at < 0) ret_at = n;
    if (a.rf_we) nrfw++;
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic br, input int di, input int dd,
                           output int ret_at, output int nrfw);
    out_t e, s;
    int n;
    logic [6:0] op;
    op = ins[6:0]; s = sel_of(op); n = 0; ret_at = -1; nrfw = 0;
    for (int k = 0; k <= di; k++) begin
      e = '0; e.state = 3'd1; e.imem_req = 1'b1; e.ir_we = (k == di);
      step($urandom, 1'($urandom), k == di, 1'($urandom), e, n, ret_at, nrfw);
    end
    e = s; e.state = 3'd2;
    step(ins, 1'($urandom), 1'($urandom), 1'($urandom), e, n, ret_at, nrfw);
    e = s; e.state = 3'd3;
    if (op == OpBranch) begin
      e.pc_we = 1'b1; e.pc_sel = br ? 2'd1 : 2'd0; e.retire = 1'b1;
    end
    step(ins, br, 1'($urandom), 1'($urandom), e, n, ret_at, nrfw);
    if (op == OpBranch) return;
    if (op == OpLoad || op == OpStore) begin
      for (int k = 0; k <= dd; k++) begin
        e = s; e.state = 3'd4; e.dmem_req = 1'b1; e.dmem_we = (op == OpStore);
        if (k == dd && op == OpStore) begin e.pc_we = 1'b1; e.retire = 1'b1; end
        step(ins, 1'($urandom), 1'($urandom), k == dd, e, n, ret_at, nrfw);
      end
      if (op == OpStore) return;
    end
    e = s; e.state = 3'd5; e.pc_we = 1'b1; e.retire = 1'b1;
    e.rf_we  = (rfw_rule(ins) != 0);
    e.wb_sel = (op == OpLoad) ? 2'd1 : ((op == OpJal || op == OpJalr) ? 2'd2 : 2'd0);
    e.pc_sel = (op == OpJal) ? 2'd1 : ((op == OpJalr) ? 2'd2 : 2'd0);
    step(ins, 1'($urandom), 1'($urandom), 1'($urandom), e, n, ret_at, nrfw);
  endtask

  task automatic do_reset(input logic second);
    out_t a;
    rst_n = 1'b0; rst2_n = 1'b0;
    instr = 32'h0; br_taken = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs dut", 32'(act1), 32'd0);
    chk("reset outputs dut_to", 32'(act2), 32'd0);
    if (second) rst2_n = 1'b1; else rst_n = 1'b1;
    @(negedge clk);
    a = second ? act2 : act1;
    chk("idle cycle", 32'(a), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t tbl [14];
  int   lat, rfw, n, ra, nr;
  out_t e;

  initial begin
    n_vec = 0; n_bad = 0; use2 = 1'b0;
    tbl[0]  = '{32'h00500093, 1'b0, 0,  0, 4,  1};  // addi x1,x0,5
    tbl[1]  = '{32'h00000463, 1'b1, 0,  0, 3,  0};  // beq taken
    tbl[2]  = '{32'h00000463, 1'b0, 0,  0, 3,  0};  // beq not taken
    tbl[3]  = '{32'h0000A103, 1'b0, 0,  3, 8,  1};  // lw x2,0(x1), slow data
    tbl[4]  = '{32'h0020A023, 1'b0, 0,  0, 4,  0};  // sw
    tbl[5]  = '{32'h00008067, 1'b0, 0,  0, 4,  0};  // jalr x0,0(x1)
    tbl[6]  = '{32'h010000EF, 1'b0, 0,  0, 4,  1};  // jal x1,16
    tbl[7]  = '{32'h123452B7, 1'b0, 0,  0, 4,  1};  // lui
    tbl[8]  = '{32'h00001197, 1'b0, 0,  0, 4,  1};  // auipc
    tbl[9]  = '{32'h002081B3, 1'b0, 2,  0, 6,  1};  // add, slow fetch
    tbl[10] = '{32'h0000000F, 1'b0, 0,  0, 4,  0};  // fence as nop
    tbl[11] = '{32'h00000073, 1'b0, 0,  0, 4,  0};  // ecall as nop
    tbl[12] = '{32'h00000013, 1'b0, 0,  0, 4,  0};  // addi x0 (rd=0)
    tbl[13] = '{32'h0000A103, 1'b0, 20, 0, 25, 1};  // no timeout when disabled

    do_reset(1'b0);
    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].ins, tbl[i].br, tbl[i].di, tbl[i].dd, lat, rfw);
      chk($sformatf("latency vec %0d", i), lat, tbl[i].exp_lat);
      chk($sformatf("rf_we count vec %0d", i), rfw, tbl[i].exp_rfw);
    end

    for (int i = 0; i < 150; i++) begin
      logic [31:0] r, ins;
      int di, dd;
      r   = $urandom;
      ins = {r[31:7], pick_op($urandom_range(0, 11))};
      di  = $urandom_range(0, 3);
      dd  = $urandom_range(0, 3);
      run_instr(ins, 1'($urandom), di, dd, lat, rfw);
      chk($sformatf("latency rnd %0d", i), lat, lat_rule(ins[6:0], di, dd));
      chk($sformatf("rf_we count rnd %0d", i), rfw, rfw_rule(ins));
    end

    // Reset in a FETCH ready cycle must kill ir_we at once, without a clock edge.
    imem_ready = 1'b1;
    #2;
    chk("ir_we before async reset", 32'(act1.ir_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset mid-fetch", 32'(act1), 32'd0);

    use2 = 1'b1;
    do_reset(1'b1);
    run_instr(32'h0000A103, 1'b0, 3, 3, lat, rfw);
    chk("latency below timeout", lat, 11);
    chk("bus_err below timeout", 32'(act2.bus_err), 32'd0);

    n = 0; ra = -1; nr = 0;
    for (int k = 0; k < 4; k++) begin
      e = '0; e.state = 3'd1; e.imem_req = 1'b1;
      step($urandom, 1'($urandom), 1'b0, 1'($urandom), e, n, ra, nr);
    end
    for (int k = 0; k < 3; k++) begin
      e = '0; e.state = 3'd6; e.bus_err = 1'b1;
      step($urandom, 1'($urandom), 1'($urandom), 1'($urandom), e, n, ra, nr);
    end
    rst2_n = 1'b0;
    #1;
    chk("async reset from halt", 32'(act2), 32'd0);

    do_reset(1'b1);
    n = 0; ra = -1; nr = 0;
    e = '0; e.state = 3'd1; e.imem_req = 1'b1; e.ir_we = 1'b1;
    step($urandom, 1'b0, 1'b1, 1'b0, e, n, ra, nr);
    e = sel_of(OpStore); e.state = 3'd2;
    step(32'h0020A023, 1'b0, 1'b0, 1'b0, e, n, ra, nr);
    e.state = 3'd3;
    step(32'h0020A023, 1'b0, 1'b0, 1'b0, e, n, ra, nr);
    for (int k = 0; k < 4; k++) begin
      e = sel_of(OpStore); e.state = 3'd4; e.dmem_req = 1'b1; e.dmem_we = 1'b1;
      step(32'h0020A023, 1'b0, 1'($urandom), 1'b0, e, n, ra, nr);
    end
    e = '0; e.state = 3'd6; e.bus_err = 1'b1;
    step(32'h0020A023, 1'b0, 1'b1, 1'b1, e, n, ra, nr);
    chk("no retire on data timeout", ra, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
